gf180mcu_fd_sc_mcu7t5v0__invpipe: RTL and testbench
===================================================

GF180MCU_FD_SC_MCU7T5V0__INVPIPE -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__invpipe

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (1..64).
REQ-002 Parameter DEPTH, default 2, number of register stages (1..8).
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RN  input  1  reset, asynchronous, active-low.
REQ-005 I  input  WIDTH  input data word.
REQ-006 I_VALID  input  1  input word offered this cycle.
REQ-007 I_READY  output  1  pipeline accepts the input word this cycle.
REQ-008 POL  input  1  per-beat mode; 1 = invert, 0 = pass through; sampled with the beat.
REQ-009 ZN  output  WIDTH  output data word, registered.
REQ-010 ZN_VALID  output  1  ZN holds a valid beat.
REQ-011 ZN_READY  input  1  downstream accepts ZN this cycle.
REQ-012 COUNT  output  4  number of beats currently held in the pipeline (0..DEPTH).
REQ-013 VDD, VSS  inout  1  supply pins; not used by logic.

Function
REQ-014 The block SHALL be a DEPTH-stage elastic pipeline, with one data register and one valid bit per stage.
REQ-015 A beat SHALL be accepted when I_VALID and I_READY are both 1; stage 0 SHALL then capture I XOR {WIDTH{POL}}.
REQ-016 Stage k SHALL be ready when its valid bit is 0 or stage k+1 is ready; the ready of the last stage SHALL equal ZN_READY; I_READY SHALL equal the ready of stage 0 (combinational, no bubble).
REQ-017 A ready stage SHALL load from its predecessor (valid and data); a stage whose predecessor is empty SHALL clear its valid bit when it hands off its beat.
REQ-018 ZN and ZN_VALID SHALL come straight from the last stage registers, with no combinational path from I.
REQ-019 Latency SHALL be exactly DEPTH cycles from acceptance to ZN_VALID while ZN_READY stays 1; throughput SHALL be 1 beat per cycle.
REQ-020 While ZN_VALID=1 and ZN_READY=0, ZN SHALL hold its value; no beat SHALL be lost, duplicated or reordered.
REQ-021 When all stages are full and ZN_READY=0, I_READY SHALL be 0.
REQ-022 When all stages are full and ZN_READY=1, I_READY SHALL be 1, and accept and emit SHALL occur in the same cycle.
REQ-023 COUNT SHALL be a registered counter: +1 on accept only, -1 on emit only, unchanged on both or neither; it SHALL never exceed DEPTH or go below 0.
REQ-024 A POL change SHALL affect only beats accepted after the change; beats already in flight SHALL keep their captured polarity.

Reset
REQ-025 On RN=0 all valid bits SHALL clear immediately; ZN SHALL be 0, ZN_VALID 0 and COUNT 0; I_READY SHALL be 1 once RN=1.
REQ-026 Reset asserted mid-transfer SHALL discard all beats in flight; no partial beat SHALL appear after release.
REQ-027 The first accept SHALL be possible on the first rising CLK edge after RN deasserts.

Configuration
REQ-028 Macro GF180MCU_FD_SC_MCU7T5V0_INVPIPE_PARITY_EN.
  - Defined: adds output ZN_PAR (1 bit), the even-parity bit of the captured word. It is computed at stage 0, carried through the pipeline with the beat, and resets to 0.
  - Undefined: ZN_PAR and its registers SHALL be absent.
  - All other behaviour SHALL be identical with or without the macro.

Verification (WIDTH=8, DEPTH=2)
REQ-029 Reset, then I=8'hA5, POL=1, I_VALID=1 for 1 cycle, ZN_READY=1 -> ZN=8'h5A with ZN_VALID=1 exactly 2 cycles after accept; COUNT goes 1,1,0.
REQ-030 Stream 8'h00..8'h07 with POL alternating 1/0, ZN_READY=1 -> outputs FF,01,FD,03,FB,05,F9,07 on consecutive cycles; I_READY stays 1.
REQ-031 ZN_READY=0 and feed 3 beats -> first 2 accepted, COUNT=2, I_READY=0, ZN stable; release ZN_READY -> beats emitted in order and the 3rd is accepted in the same cycle as the first emit.
REQ-032 With 2 beats in flight, pulse RN=0 between clock edges -> ZN_VALID=0, ZN=8'h00 and COUNT=0 immediately; the in-flight beats never appear.
REQ-033 Macro defined, I=8'h07, POL=0 -> ZN_PAR=1 with ZN=8'h07; I=8'h07, POL=1 -> ZN=8'hF8 and ZN_PAR=1.
REQ-034 Random I_VALID and ZN_READY for 10k cycles against a scoreboard -> no loss, reordering or duplication; COUNT always matches the scoreboard occupancy.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__invpipe.sv
// Elastic DEPTH-stage pipeline that inverts or passes each beat per its POL bit.
// Optional even-parity sideband enabled by GF180MCU_FD_SC_MCU7T5V0_INVPIPE_PARITY_EN.
module gf180mcu_fd_sc_mcu7t5v0__invpipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic             POL,
  output logic [WIDTH-1:0] ZN,
  output logic             ZN_VALID,
  input  logic             ZN_READY,
  output logic [3:0]       COUNT,
`ifdef GF180MCU_FD_SC_MCU7T5V0_INVPIPE_PARITY_EN
  output logic             ZN_PAR,
`endif
  inout  wire              VDD,
  inout  wire              VSS
);

  logic [WIDTH-1:0] data_s [DEPTH];
  logic [DEPTH-1:0] valid_s;
  logic [DEPTH-1:0] stage_rdy;
  logic [WIDTH-1:0] cap_word;
  logic             accept;
  logic             emit;
  logic [3:0]       count_q;

  assign cap_word = I ^ {WIDTH{POL}};

  // Ready ripples from the output back to stage 0; an empty stage is always ready.
  always_comb begin : ready_chain
    logic r;
    r         = ZN_READY;
    stage_rdy = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      r            = !valid_s[k] || r;
      stage_rdy[k] = r;
    end
  end

  assign I_READY = stage_rdy[0];
  assign accept  = I_VALID && stage_rdy[0];
  assign emit    = valid_s[DEPTH-1] && ZN_READY;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             vin;
    logic [WIDTH-1:0] din;
    logic             v_q;
    logic [WIDTH-1:0] d_q;

    if (k == 0) begin : g_head
      assign vin = I_VALID;
      assign din = cap_word;
    end else begin : g_body
      assign vin = valid_s[k-1];
      assign din = data_s[k-1];
    end

    always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (stage_rdy[k]) begin
        v_q <= vin;
        if (vin) d_q <= din;
      end
    end

    assign valid_s[k] = v_q;
    assign data_s[k]  = d_q;
  end

`ifdef GF180MCU_FD_SC_MCU7T5V0_INVPIPE_PARITY_EN
  logic [DEPTH-1:0] par_s;

  // Parity travels with the beat, so it follows the same load enables as the data.
  for (genvar k = 0; k < DEPTH; k++) begin : g_par
    logic pin;
    logic p_q;

    if (k == 0) begin : g_head
      assign pin = ^cap_word;
    end else begin : g_body
      assign pin = par_s[k-1];
    end

    always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
        p_q <= 1'b0;
      end else if (stage_rdy[k] && g_stage[k].vin) begin
        p_q <= pin;
      end
    end

    assign par_s[k] = p_q;
  end

  assign ZN_PAR = par_s[DEPTH-1];
`endif

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      count_q <= 4'd0;
    end else if (accept && !emit) begin
      count_q <= count_q + 4'd1;
    end else if (emit && !accept) begin
      count_q <= count_q - 4'd1;
    end
  end

  assign ZN       = data_s[DEPTH-1];
  assign ZN_VALID = valid_s[DEPTH-1];
  assign COUNT    = count_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__invpipe.sv
// Directed and randomized checks of the inverting elastic pipeline (WIDTH=8, DEPTH=2).
module tb_gf180mcu_fd_sc_mcu7t5v0__invpipe;

  logic       clk = 1'b0;
  logic       rn;
  logic [7:0] i;
  logic       i_valid;
  logic       i_ready;
  logic       pol;
  logic [7:0] zn;
  logic       zn_valid;
  logic       zn_ready;
  logic [3:0] count;
`ifdef GF180MCU_FD_SC_MCU7T5V0_INVPIPE_PARITY_EN
  logic       zn_par;
`endif
  wire        vdd;
  wire        vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  gf180mcu_fd_sc_mcu7t5v0__invpipe #(.WIDTH(8), .DEPTH(2)) dut (
    .CLK(clk), .RN(rn), .I(i), .I_VALID(i_valid), .I_READY(i_ready), .POL(pol),
    .ZN(zn), .ZN_VALID(zn_valid), .ZN_READY(zn_ready), .COUNT(count),
`ifdef GF180MCU_FD_SC_MCU7T5V0_INVPIPE_PARITY_EN
    .ZN_PAR(zn_par),
`endif
    .VDD(vdd), .VSS(vss)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rn = 1'b0; i = 8'h00; i_valid = 1'b0; pol = 1'b0; zn_ready = 1'b1;
    #12;
    n_cmp++; if (zn_valid !== 1'b0) begin n_err++; $display("FAIL reset_zn_valid got=%b exp=0", zn_valid); end
    n_cmp++; if (zn !== 8'h00) begin n_err++; $display("FAIL reset_zn got=%h exp=00", zn); end
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
`ifdef GF180MCU_FD_SC_MCU7T5V0_INVPIPE_PARITY_EN
    n_cmp++; if (zn_par !== 1'b0) begin n_err++; $display("FAIL reset_zn_par got=%b exp=0", zn_par); end
`endif
    #10;
    rn = 1'b1;
    #1;
    n_cmp++; if (i_ready !== 1'b1) begin n_err++; $display("FAIL reset_i_ready got=%b exp=1", i_ready); end
  endtask

  task automatic test_single;
    i = 8'hA5; pol = 1'b1; i_valid = 1'b1; zn_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL single_count1 got=%0d exp=1", count); end
    n_cmp++; if (zn_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid got=%b exp=0", zn_valid); end
    tick();
    n_cmp++; if (zn_valid !== 1'b1 || zn !== 8'h5A) begin n_err++; $display("FAIL single_out got=%b/%h exp=1/5a", zn_valid, zn); end
    n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL single_count2 got=%0d exp=1", count); end
    tick();
    n_cmp++; if (zn_valid !== 1'b0) begin n_err++; $display("FAIL single_drain_valid got=%b exp=0", zn_valid); end
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL single_count3 got=%0d exp=0", count); end
  endtask

  task automatic test_stream;
    logic [7:0] exp_s [8];
    exp_s = '{8'hFF, 8'h01, 8'hFD, 8'h03, 8'hFB, 8'h05, 8'hF9, 8'h07};
    zn_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (t < 8) begin
        i = 8'(t); pol = (t % 2 == 0); i_valid = 1'b1;
        #1;
        n_cmp++; if (i_ready !== 1'b1) begin n_err++; $display("FAIL stream_i_ready t=%0d got=%b exp=1", t, i_ready); end
      end else begin
        i_valid = 1'b0;
      end
      tick();
      if (t >= 1 && t <= 8) begin
        n_cmp++;
        if (zn_valid !== 1'b1 || zn !== exp_s[t-1]) begin
          n_err++; $display("FAIL stream_out beat=%0d got=%b/%h exp=1/%h", t - 1, zn_valid, zn, exp_s[t-1]);
        end
      end
    end
    n_cmp++; if (zn_valid !== 1'b0) begin n_err++; $display("FAIL stream_tail_valid got=%b exp=0", zn_valid); end
  endtask

  task automatic test_backpressure;
    zn_ready = 1'b0; pol = 1'b0;
    i = 8'h11; i_valid = 1'b1;
    tick();
    i = 8'h22;
    #1;
    n_cmp++; if (i_ready !== 1'b1) begin n_err++; $display("FAIL bp_second_ready got=%b exp=1", i_ready); end
    tick();
    i = 8'h33;
    #1;
    n_cmp++; if (i_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready got=%b exp=0", i_ready); end
    n_cmp++; if (count !== 4'd2) begin n_err++; $display("FAIL bp_count got=%0d exp=2", count); end
    n_cmp++; if (zn_valid !== 1'b1 || zn !== 8'h11) begin n_err++; $display("FAIL bp_head got=%b/%h exp=1/11", zn_valid, zn); end
    tick();
    n_cmp++; if (zn !== 8'h11 || count !== 4'd2) begin n_err++; $display("FAIL bp_hold got=%h/%0d exp=11/2", zn, count); end
    zn_ready = 1'b1;
    #1;
    n_cmp++; if (i_ready !== 1'b1) begin n_err++; $display("FAIL bp_pass_ready got=%b exp=1", i_ready); end
    tick();
    i_valid = 1'b0;
    n_cmp++; if (zn !== 8'h22 || count !== 4'd2) begin n_err++; $display("FAIL bp_swap got=%h/%0d exp=22/2", zn, count); end
    tick();
    n_cmp++; if (zn_valid !== 1'b1 || zn !== 8'h33 || count !== 4'd1) begin n_err++; $display("FAIL bp_third got=%b/%h/%0d exp=1/33/1", zn_valid, zn, count); end
    tick();
    n_cmp++; if (zn_valid !== 1'b0 || count !== 4'd0) begin n_err++; $display("FAIL bp_empty got=%b/%0d exp=0/0", zn_valid, count); end
  endtask

  task automatic test_midreset;
    zn_ready = 1'b0; pol = 1'b1;
    i = 8'h44; i_valid = 1'b1;
    tick();
    i = 8'h55;
    tick();
    i_valid = 1'b0;
    n_cmp++; if (count !== 4'd2) begin n_err++; $display("FAIL mr_preload_count got=%0d exp=2", count); end
    #2;
    rn = 1'b0;
    #1;
    n_cmp++; if (zn_valid !== 1'b0 || zn !== 8'h00) begin n_err++; $display("FAIL mr_async_out got=%b/%h exp=0/00", zn_valid, zn); end
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL mr_async_count got=%0d exp=0", count); end
    tick();
    rn = 1'b1;
    zn_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_cmp++; if (zn_valid !== 1'b0 || count !== 4'd0) begin n_err++; $display("FAIL mr_ghost t=%0d got=%b/%0d exp=0/0", t, zn_valid, count); end
    end
    i = 8'h3C; pol = 1'b0; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    n_cmp++; if (zn_valid !== 1'b1 || zn !== 8'h3C) begin n_err++; $display("FAIL mr_after got=%b/%h exp=1/3c", zn_valid, zn); end
    tick();
  endtask

`ifdef GF180MCU_FD_SC_MCU7T5V0_INVPIPE_PARITY_EN
  task automatic test_parity;
    zn_ready = 1'b1;
    i = 8'h07; pol = 1'b0; i_valid = 1'b1;
    tick();
    pol = 1'b1;
    tick();
    i_valid = 1'b0;
    n_cmp++; if (zn !== 8'h07 || zn_par !== 1'b1) begin n_err++; $display("FAIL par_pass got=%h/%b exp=07/1", zn, zn_par); end
    tick();
    n_cmp++; if (zn !== 8'hF8 || zn_par !== 1'b1) begin n_err++; $display("FAIL par_inv got=%h/%b exp=f8/1", zn, zn_par); end
    tick();
  endtask
`endif

  task automatic test_random;
    logic [7:0] sb[$];
    logic [7:0] want;
    int         drain;
    for (int c = 0; c < 10000; c++) begin
      i        = 8'($urandom_range(0, 255));
      pol      = 1'($urandom_range(0, 1));
      i_valid  = ($urandom_range(0, 3) != 0);
      zn_ready = ($urandom_range(0, 2) != 0);
      #1;
      n_cmp++;
      if (i_ready !== ((sb.size() < 2) || zn_ready)) begin
        n_err++; $display("FAIL rnd_ready c=%0d got=%b occ=%0d zr=%b", c, i_ready, sb.size(), zn_ready);
      end
      if (zn_valid && zn_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL rnd_dup c=%0d got=%h exp=none", c, zn);
        end else begin
          want = sb.pop_front();
          if (zn !== want) begin n_err++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, zn, want); end
        end
      end
      if (i_valid && i_ready) sb.push_back(i ^ {8{pol}});
      tick();
      n_cmp++;
      if (count !== 4'(sb.size())) begin n_err++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, sb.size()); end
    end
    i_valid = 1'b0; zn_ready = 1'b1;
    drain = 0;
    while (sb.size() != 0 && drain < 20) begin
      #1;
      if (zn_valid) begin
        want = sb.pop_front();
        n_cmp++; if (zn !== want) begin n_err++; $display("FAIL rnd_drain got=%h exp=%h", zn, want); end
      end
      tick();
      drain++;
    end
    n_cmp++; if (sb.size() != 0 || count !== 4'd0) begin n_err++; $display("FAIL rnd_leftover got=%0d/%0d exp=0/0", sb.size(), count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_midreset();
`ifdef GF180MCU_FD_SC_MCU7T5V0_INVPIPE_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
